pe_mac_accum: RTL

- PE arithmetic unit that sits directly downstream of the input-feature pad and the weight pad.
- Consumes paired ipix/wpix beats through valid/ready handshakes and multiplies them as signed values.
- Accumulates products over one window, delimited by i_cont_lastPix, into a single psum.
- Presents the finished psum to the psum/output stage through a registered valid/ready port.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_mult_reg.sv | 63 ++++++
 rtl/pe_mac_accum.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE MAC accumulator (pe_mac_accum).
// Width helpers assume 2*DWd <= PROD_MAX_WD and AccWd <= ACC_MAX_WD.
package pe_pkg;

  localparam int DWD_DEF     = 16;
  localparam int ACC_WD_DEF  = 40;
  localparam int CNT_WD_DEF  = 16;
  localparam int PROD_MAX_WD = 64;
  localparam int ACC_MAX_WD  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } MacState;

  // Sign-extends a product; callers size-cast in and out to their own widths.
  function automatic logic signed [ACC_MAX_WD-1:0] sext_prod(
    input logic signed [PROD_MAX_WD-1:0] prod
  );
    return ACC_MAX_WD'(prod);
  endfunction

endpackage

// File: rtl/pe_mult_reg.sv
// Stage-1 signed multiplier and product register of the PE MAC.
// Optional zero-operand gating is enabled by defining PE_MAC_ZERO_SKIP_EN.
module pe_mult_reg
  import pe_pkg::*;
#(
  parameter int DWd = DWD_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  clr,
  input  logic                  stall,
  input  logic                  fire,
  input  logic                  last,
  input  logic signed [DWd-1:0] a,
  input  logic signed [DWd-1:0] b,
  input  logic                  a_zero,
  input  logic                  b_zero,
  output logic signed [2*DWd-1:0] prod_r,
  output logic                  p_valid,
  output logic                  p_last,
  output logic                  skip_fire
);

  logic                  skip;
  logic                  use_mul;
  logic signed [DWd-1:0] mul_a;
  logic signed [DWd-1:0] mul_b;

`ifdef PE_MAC_ZERO_SKIP_EN
  assign skip = a_zero | b_zero;
`else
  logic unused_zero;
  assign unused_zero = a_zero ^ b_zero;
  assign skip        = 1'b0;
`endif

  // Operands are isolated to zero whenever no real product is needed.
  assign use_mul   = fire && !skip;
  assign mul_a     = use_mul ? a : '0;
  assign mul_b     = use_mul ? b : '0;
  assign skip_fire = fire && skip;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prod_r  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (clr) begin
      prod_r  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (!stall) begin
      p_valid <= fire;
      if (fire) begin
        prod_r <= (2*DWd)'(mul_a) * (2*DWd)'(mul_b);
        p_last <= last;
      end
    end
  end

endmodule

// File: rtl/pe_mac_accum.sv
// PE MAC: signed ipix*wpix products accumulated per window into a registered psum.
// Optional zero-skip (o_skip_cnt, operand gating) via PE_MAC_ZERO_SKIP_EN.
module pe_mac_accum
  import pe_pkg::*;
#(
  parameter int DWd   = DWD_DEF,
  parameter int AccWd = ACC_WD_DEF,
  parameter int CntWd = CNT_WD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_cont_reset,
  input  logic             i_cont_stall,
  input  logic             i_cont_start,
  input  logic             i_cont_done,
  input  logic             i_cont_lastPix,
  input  logic             i_ipix_valid,
  input  logic [DWd-1:0]   i_ipix_data,
  input  logic             i_ipix_zero,
  output logic             o_ipix_ready,
  input  logic             i_wpix_valid,
  input  logic [DWd-1:0]   i_wpix_data,
  input  logic             i_wpix_zero,
  output logic             o_wpix_ready,
  output logic             o_psum_valid,
  output logic [AccWd-1:0] o_psum_data,
  input  logic             i_psum_ready,
  output logic             o_busy
`ifdef PE_MAC_ZERO_SKIP_EN
  ,
  output logic [CntWd-1:0] o_skip_cnt
`endif
);

  MacState                 state, state_nxt;
  logic                    done_pend, done_pend_nxt;
  logic                    first;
  logic signed [AccWd-1:0] acc;
  logic signed [AccWd-1:0] acc_add;
  logic signed [AccWd-1:0] acc_sum;
  logic signed [2*DWd-1:0] prod_r;
  logic                    p_valid, p_last, skip_fire;
  logic                    ready, fire, psum_hs, win_idle;

  // Holding off pairs while a psum is unread keeps it from being overwritten.
  assign ready        = (state == RUN) && !i_cont_stall && !o_psum_valid;
  assign o_ipix_ready = ready;
  assign o_wpix_ready = ready;
  assign fire         = ready && i_ipix_valid && i_wpix_valid;
  assign psum_hs      = o_psum_valid && i_psum_ready && !i_cont_stall;
  assign win_idle     = first && !p_valid;
  assign o_busy       = (state != IDLE);

  pe_mult_reg #(.DWd(DWd)) u_mult (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .clr       (i_cont_reset),
    .stall     (i_cont_stall),
    .fire      (fire),
    .last      (i_cont_lastPix),
    .a         ($signed(i_ipix_data)),
    .b         ($signed(i_wpix_data)),
    .a_zero    (i_ipix_zero),
    .b_zero    (i_wpix_zero),
    .prod_r    (prod_r),
    .p_valid   (p_valid),
    .p_last    (p_last),
    .skip_fire (skip_fire)
  );

  assign acc_add = AccWd'(sext_prod(PROD_MAX_WD'(prod_r)));
  assign acc_sum = (first ? '0 : acc) + acc_add;

  // NOTE: every always_comb output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    done_pend_nxt = done_pend;
    if (!i_cont_stall) begin
      case (state)
        IDLE: begin
          if (i_cont_start) begin
            state_nxt     = RUN;
            done_pend_nxt = 1'b0;
          end
        end
        RUN: begin
          if (fire && i_cont_lastPix) begin
            state_nxt = FLUSH;
            if (i_cont_done) done_pend_nxt = 1'b1;
          end else if (i_cont_done) begin
            if (win_idle && !fire) state_nxt = IDLE;
            else                   done_pend_nxt = 1'b1;
          end
        end
        FLUSH: begin
          if (i_cont_done) done_pend_nxt = 1'b1;
          if (psum_hs) begin
            state_nxt     = (done_pend || i_cont_done) ? IDLE : RUN;
            done_pend_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      done_pend    <= 1'b0;
      first        <= 1'b1;
      acc          <= '0;
      o_psum_valid <= 1'b0;
      o_psum_data  <= '0;
    end else if (i_cont_reset) begin
      state        <= IDLE;
      done_pend    <= 1'b0;
      first        <= 1'b1;
      acc          <= '0;
      o_psum_valid <= 1'b0;
      o_psum_data  <= '0;
    end else begin
      state     <= state_nxt;
      done_pend <= done_pend_nxt;
      if (!i_cont_stall) begin
        if (psum_hs) o_psum_valid <= 1'b0;
        if (p_valid) begin
          acc <= acc_sum;
          if (p_last) begin
            o_psum_data  <= acc_sum;
            o_psum_valid <= 1'b1;
            first        <= 1'b1;
          end else begin
            first <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PE_MAC_ZERO_SKIP_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_skip_cnt <= '0;
    end else if (i_cont_reset) begin
      o_skip_cnt <= '0;
    end else if (!i_cont_stall) begin
      if (state == IDLE && i_cont_start)      o_skip_cnt <= '0;
      else if (skip_fire && o_skip_cnt != '1) o_skip_cnt <= o_skip_cnt + 1'b1;
    end
  end
`else
  logic [CntWd:0] unused_skip;
  assign unused_skip = {skip_fire, {CntWd{1'b0}}};
`endif

endmodule
